// File: rtl/hdr_pkg.sv
// Shared constants and FSM encoding for the double-buffered HDR luma LUT.
package hdr_pkg;

  localparam int unsigned Y_W       = 8;
  localparam int unsigned PIX_W     = 24;
  localparam int unsigned LUT_DEPTH = 256;

  localparam int unsigned Y_MSB = 23;
  localparam int unsigned Y_LSB = 16;
  localparam int unsigned U_MSB = 15;
  localparam int unsigned U_LSB = 8;
  localparam int unsigned V_MSB = 7;
  localparam int unsigned V_LSB = 0;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    PEND = 2'd2
  } hdr_state_e;

endpackage

// File: rtl/hdr_lut_bank.sv
// One 256x8 LUT bank: synchronous write, asynchronous read, no reset (filled by INIT).
module hdr_lut_bank
  import hdr_pkg::*;
(
  input  logic           clk,
  input  logic           we,
  input  logic [Y_W-1:0] waddr,
  input  logic [Y_W-1:0] wdata,
  input  logic [Y_W-1:0] raddr,
  output logic [Y_W-1:0] rdata
);

  logic [Y_W-1:0] mem [LUT_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hdr_lut_ctrl.sv
// HDR luma tone-mapping: two LUT banks, host writes the shadow bank and the
// swap is deferred to the next vsync rise; 2-cycle pixel pipeline.
module hdr_lut_ctrl
  import hdr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Pre_vsync,
  input  logic [PIX_W-1:0] Pre_YUV,
  input  logic             Pre_YUV_en,
  input  logic             hdr_bypass,
  input  logic             cfg_wr_en,
  input  logic [Y_W-1:0]   cfg_addr,
  input  logic [Y_W-1:0]   cfg_data,
  input  logic             cfg_commit,
  output logic             cfg_busy,
  output logic             cfg_err,
  output logic             active_bank,
  output logic [PIX_W-1:0] Post_YUV,
  output logic             Post_YUV_en
);

  hdr_state_e     state_q, state_d;
  logic [Y_W-1:0] init_cnt;
  logic           vsync_d;
  logic           vsync_rise;
  logic           init_we;
  logic           shadow_we;
  logic           drop;
  logic           swap;

  logic           bank0_we, bank1_we;
  logic [Y_W-1:0] wr_addr, wr_data;
  logic [Y_W-1:0] rd0, rd1;

  logic [PIX_W-1:0] s1_yuv;
  logic             s1_en;
  logic             s1_sel;
  logic             s1_byp;
  logic [Y_W-1:0]   y_map;

  assign vsync_rise = Pre_vsync & ~vsync_d;
  assign cfg_busy   = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    init_we   = 1'b0;
    shadow_we = 1'b0;
    drop      = 1'b0;
    swap      = 1'b0;
    case (state_q)
      INIT: begin
        init_we = 1'b1;
        drop    = cfg_wr_en | cfg_commit;
        if (init_cnt == '1) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        // A vsync rise in this cycle is ignored; the swap waits for the next one.
        shadow_we = cfg_wr_en;
        if (cfg_commit) begin
          state_d = PEND;
        end
      end
      PEND: begin
        drop = cfg_wr_en | cfg_commit;
        if (vsync_rise) begin
          swap    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // INIT writes the identity curve into both banks; otherwise only the shadow.
  assign wr_addr  = init_we ? init_cnt : cfg_addr;
  assign wr_data  = init_we ? init_cnt : cfg_data;
  assign bank0_we = init_we | (shadow_we &  active_bank);
  assign bank1_we = init_we | (shadow_we & ~active_bank);

  hdr_lut_bank u_bank0 (
    .clk   (clk),
    .we    (bank0_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (s1_yuv[Y_MSB:Y_LSB]),
    .rdata (rd0)
  );

  hdr_lut_bank u_bank1 (
    .clk   (clk),
    .we    (bank1_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (s1_yuv[Y_MSB:Y_LSB]),
    .rdata (rd1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt    <= '0;
      vsync_d     <= 1'b0;
      active_bank <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_cnt <= (state_q == INIT) ? init_cnt + 1'b1 : '0;
      vsync_d  <= Pre_vsync;
      cfg_err  <= drop;
      if (swap) begin
        active_bank <= ~active_bank;
      end
    end
  end

  assign y_map = s1_byp ? s1_yuv[Y_MSB:Y_LSB] : (s1_sel ? rd1 : rd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_yuv      <= '0;
      s1_en       <= 1'b0;
      s1_sel      <= 1'b0;
      s1_byp      <= 1'b0;
      Post_YUV    <= '0;
      Post_YUV_en <= 1'b0;
    end else begin
      s1_yuv      <= Pre_YUV;
      s1_en       <= Pre_YUV_en;
      s1_sel      <= active_bank;
      s1_byp      <= hdr_bypass | (state_q == INIT);
      Post_YUV    <= {y_map, s1_yuv[U_MSB:U_LSB], s1_yuv[V_MSB:V_LSB]};
      Post_YUV_en <= s1_en;
    end
  end

endmodule

// File: tb/tb_hdr_lut_ctrl.sv
// Directed self-checking bench for hdr_lut_ctrl.
module tb_hdr_lut_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Pre_vsync = 1'b0;
  logic [23:0] Pre_YUV = '0;
  logic        Pre_YUV_en = 1'b0;
  logic        hdr_bypass = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_busy;
  logic        cfg_err;
  logic        active_bank;
  logic [23:0] Post_YUV;
  logic        Post_YUV_en;

  int checks = 0;
  int failures = 0;

  hdr_lut_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Pre_vsync   (Pre_vsync),
    .Pre_YUV     (Pre_YUV),
    .Pre_YUV_en  (Pre_YUV_en),
    .hdr_bypass  (hdr_bypass),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .cfg_busy    (cfg_busy),
    .cfg_err     (cfg_err),
    .active_bank (active_bank),
    .Post_YUV    (Post_YUV),
    .Post_YUV_en (Post_YUV_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pix(input logic [7:0] y, output logic [23:0] o, output logic oe);
    Pre_YUV    = {y, 8'hA5, 8'h3C};
    Pre_YUV_en = 1'b1;
    tick();
    Pre_YUV_en = 1'b0;
    tick();
    o  = Post_YUV;
    oe = Post_YUV_en;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (cfg_busy && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL %s: busy cycles=%0d required=256", name, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({Post_YUV, Post_YUV_en, cfg_err, active_bank, cfg_busy} !== {24'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state: yuv=%h en=%b err=%b bank=%b busy=%b required 000000 0 0 0 1",
               Post_YUV, Post_YUV_en, cfg_err, active_bank, cfg_busy);
    end
    rst_n = 1'b1;
    // A write during INIT must be dropped and flagged.
    cfg_wr_en = 1'b1;
    cfg_addr  = 8'h10;
    cfg_data  = 8'h99;
    tick();
    cfg_wr_en = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin
      failures++;
      $display("FAIL init_drop_err: cfg_err=%b required=1", cfg_err);
    end
    begin
      int n = 1;
      while (cfg_busy && n < 400) begin
        tick();
        n++;
      end
      checks++;
      if (n !== 256) begin
        failures++;
        $display("FAIL init_length: busy cycles=%0d required=256", n);
      end
    end
  endtask

  task automatic test_identity();
    logic [23:0] o;
    logic        oe;
    Pre_YUV    = 24'h40_80_80;
    Pre_YUV_en = 1'b1;
    tick();
    Pre_YUV_en = 1'b0;
    checks++;
    if (Post_YUV_en !== 1'b0) begin
      failures++;
      $display("FAIL latency_en_early: en=%b required=0", Post_YUV_en);
    end
    tick();
    checks++;
    if (Post_YUV !== 24'h40_80_80 || Post_YUV_en !== 1'b1) begin
      failures++;
      $display("FAIL identity_pix: yuv=%h en=%b required 408080 1", Post_YUV, Post_YUV_en);
    end
    run_pix(8'h10, o, oe);
    checks++;
    if (o !== 24'h10_A5_3C) begin
      failures++;
      $display("FAIL init_write_dropped: yuv=%h required=10a53c", o);
    end
  endtask

  task automatic test_commit();
    logic [23:0] o;
    logic        oe;
    cfg_wr_en = 1'b1;
    cfg_addr  = 8'h40;
    cfg_data  = 8'h6A;
    tick();
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    run_pix(8'h40, o, oe);
    checks++;
    if (cfg_busy !== 1'b1 || active_bank !== 1'b0 || o !== 24'h40_A5_3C) begin
      failures++;
      $display("FAIL pend_old_curve: busy=%b bank=%b yuv=%h required 1 0 40a53c", cfg_busy, active_bank, o);
    end
    Pre_vsync = 1'b1;
    tick();
    checks++;
    if (active_bank !== 1'b1 || cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL swap: bank=%b busy=%b required 1 0", active_bank, cfg_busy);
    end
    Pre_vsync = 1'b0;
    run_pix(8'h40, o, oe);
    checks++;
    if (o !== 24'h6A_A5_3C || oe !== 1'b1) begin
      failures++;
      $display("FAIL new_curve: yuv=%h en=%b required 6aa53c 1", o, oe);
    end
  endtask

  task automatic test_commit_with_vsync();
    logic [23:0] o;
    logic        oe;
    cfg_commit = 1'b1;
    Pre_vsync  = 1'b1;
    tick();
    cfg_commit = 1'b0;
    checks++;
    if (active_bank !== 1'b1 || cfg_busy !== 1'b1) begin
      failures++;
      $display("FAIL commit_same_vsync: bank=%b busy=%b required 1 1", active_bank, cfg_busy);
    end
    // Dropped shadow write while pending: shadow is bank0.
    cfg_wr_en = 1'b1;
    cfg_addr  = 8'h00;
    cfg_data  = 8'hFF;
    tick();
    cfg_wr_en = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin
      failures++;
      $display("FAIL pend_err_pulse: cfg_err=%b required=1", cfg_err);
    end
    Pre_vsync = 1'b0;
    tick();
    checks++;
    if (cfg_err !== 1'b0 || active_bank !== 1'b1) begin
      failures++;
      $display("FAIL pend_err_width: cfg_err=%b bank=%b required 0 1", cfg_err, active_bank);
    end
    Pre_vsync = 1'b1;
    tick();
    Pre_vsync = 1'b0;
    checks++;
    if (active_bank !== 1'b0 || cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL second_rise_swap: bank=%b busy=%b required 0 0", active_bank, cfg_busy);
    end
    run_pix(8'h00, o, oe);
    checks++;
    if (o !== 24'h00_A5_3C) begin
      failures++;
      $display("FAIL pend_write_dropped: yuv=%h required=00a53c", o);
    end
    // Return to bank1 (holds 0x40 -> 0x6A).
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    Pre_vsync = 1'b1;
    tick();
    Pre_vsync = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    logic [23:0] o;
    logic        oe;
    logic [7:0]  exp_y [4];
    logic        byp   [4];
    hdr_bypass = 1'b1;
    run_pix(8'h40, o, oe);
    checks++;
    if (o !== 24'h40_A5_3C || active_bank !== 1'b1) begin
      failures++;
      $display("FAIL bypass_static: yuv=%h bank=%b required 40a53c 1", o, active_bank);
    end
    byp[0] = 1'b1; byp[1] = 1'b1; byp[2] = 1'b0; byp[3] = 1'b0;
    exp_y[0] = 8'h40; exp_y[1] = 8'h40; exp_y[2] = 8'h6A; exp_y[3] = 8'h6A;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        Pre_YUV    = {8'h40, 8'h11, 8'(i)};
        Pre_YUV_en = 1'b1;
        hdr_bypass = byp[i];
      end else begin
        Pre_YUV_en = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        checks++;
        if (Post_YUV !== {exp_y[i-1], 8'h11, 8'(i-1)} || Post_YUV_en !== 1'b1) begin
          failures++;
          $display("FAIL bypass_toggle[%0d]: yuv=%h en=%b required %h 1",
                   i - 1, Post_YUV, Post_YUV_en, {exp_y[i-1], 8'h11, 8'(i-1)});
        end
      end else if (i == 5) begin
        checks++;
        if (Post_YUV_en !== 1'b0) begin
          failures++;
          $display("FAIL bypass_en_tail: en=%b required=0", Post_YUV_en);
        end
      end
    end
  endtask

  task automatic test_reset_in_pend();
    logic [23:0] o;
    logic        oe;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    Pre_YUV    = 24'h40_22_33;
    Pre_YUV_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    Pre_YUV_en = 1'b0;
    checks++;
    if (Post_YUV_en !== 1'b0 || active_bank !== 1'b0 || cfg_busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_pend: en=%b bank=%b busy=%b required 0 0 1", Post_YUV_en, active_bank, cfg_busy);
    end
    rst_n = 1'b1;
    wait_init("reinit_length");
    run_pix(8'hFF, o, oe);
    checks++;
    if (o !== 24'hFF_A5_3C || oe !== 1'b1) begin
      failures++;
      $display("FAIL reinit_ff: yuv=%h en=%b required ffa53c 1", o, oe);
    end
    // Bank1 also returns to identity.
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    Pre_vsync = 1'b1;
    tick();
    Pre_vsync = 1'b0;
    run_pix(8'h40, o, oe);
    checks++;
    if (o !== 24'h40_A5_3C || active_bank !== 1'b1) begin
      failures++;
      $display("FAIL reinit_bank1: yuv=%h bank=%b required 40a53c 1", o, active_bank);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_commit();
    test_commit_with_vsync();
    test_bypass();
    hdr_bypass = 1'b0;
    test_reset_in_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
